// File: rtl/alu_control_mc.sv
// alu_control_mc: registered ALU control unit between ID/EX decode and execute.
// Decodes ALUOp/Funct/MExt into an ALU operation code covering RV32I ALU ops and
// (optionally) RV32M MUL/DIV/REM, and sequences multi-cycle ops by stalling the
// pipeline until the iterative datapath result is due.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous, active-high
//   flush      synchronous pipeline flush; drops in-flight and coincident ops
//   in_valid   decoded instruction present
//   in_ready   ~stall; accept on in_valid & in_ready
//   ALUOp      00 ld/st/imm, 01 branch, 10 R-type, 11 reserved
//   Funct      {funct7[5], funct3}
//   MExt       funct7[0], selects RV32M
//   Operation  registered ALU op code (zero-extended to OP_W)
//   out_valid  Operation valid for EX this cycle
//   illegal    registered: last accepted combination was undefined
//   stall      multi-cycle op in progress
module alu_control_mc #(
    parameter int unsigned OP_W       = 4,
    parameter bit          ENABLE_M   = 1'b1,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [3:0]      Funct,
    input  logic            MExt,
    output logic [OP_W-1:0] Operation,
    output logic            out_valid,
    output logic            illegal,
    output logic            stall
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] MulCnt = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] DivCnt = CntW'(DIV_CYCLES - 1);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSlt  = 4'b0100;
    localparam logic [3:0] OpSltu = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSll  = 4'b0111;
    localparam logic [3:0] OpSrl  = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;
    localparam logic [3:0] OpMul  = 4'b1010;
    localparam logic [3:0] OpDiv  = 4'b1011;
    localparam logic [3:0] OpRem  = 4'b1100;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            illegal_q, illegal_d;
    logic            out_valid_q, out_valid_d;

    logic [2:0]      funct3;
    logic [3:0]      dec_op;
    logic            dec_illegal;
    logic            dec_multi;
    logic [CntW-1:0] dec_cnt;

    assign funct3 = Funct[2:0];

    // Illegal combinations leave dec_op at ADD so EX always sees a harmless op.
    always_comb begin
        dec_op      = OpAdd;
        dec_illegal = 1'b0;
        dec_multi   = 1'b0;
        dec_cnt     = '0;
        case (ALUOp)
            2'b00: begin
                if (funct3 == 3'b001) dec_op = OpSll;
            end
            2'b01: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) dec_illegal = 1'b1;
                else                                      dec_op      = OpSub;
            end
            2'b10: begin
                if (MExt) begin
                    if (ENABLE_M) begin
                        case (funct3)
                            3'b000: begin dec_op = OpMul; dec_multi = 1'b1; dec_cnt = MulCnt; end
                            3'b100: begin dec_op = OpDiv; dec_multi = 1'b1; dec_cnt = DivCnt; end
                            3'b110: begin dec_op = OpRem; dec_multi = 1'b1; dec_cnt = DivCnt; end
                            default: dec_illegal = 1'b1;
                        endcase
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else begin
                    case (Funct)
                        4'b0000: dec_op = OpAdd;
                        4'b1000: dec_op = OpSub;
                        4'b0111: dec_op = OpAnd;
                        4'b0110: dec_op = OpOr;
                        4'b0100: dec_op = OpXor;
                        4'b0001: dec_op = OpSll;
                        4'b0101: dec_op = OpSrl;
                        4'b1101: dec_op = OpSra;
                        4'b0010: dec_op = OpSlt;
                        4'b0011: dec_op = OpSltu;
                        default: dec_illegal = 1'b1;
                    endcase
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        illegal_d   = illegal_q;
        out_valid_d = 1'b0;
        if (flush) begin
            // Flush wins over any coincident accept; Operation/illegal hold.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_d      = OP_W'(dec_op);
                        illegal_d = dec_illegal;
                        if (dec_multi) begin
                            state_d = StBusy;
                            cnt_d   = dec_cnt;
                        end else begin
                            out_valid_d = 1'b1;
                        end
                    end
                end
                StBusy: begin
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= OP_W'(OpAdd);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign stall     = (state_q == StBusy);
    assign Operation = op_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// Scoreboard bench for alu_control_mc. Two instances share stimulus: dut_a with
// defaults (RV32M enabled) and dut_b with ENABLE_M=0. The driver predicts each
// accepted op from a table-driven reference decode and pushes {op, illegal,
// due cycle} into a per-instance queue; monitors pop on out_valid.
module tb_alu_control_mc;

    localparam int MUL_L = 4;
    localparam int DIV_L = 16;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, mext;
    logic [1:0] alu_op;
    logic [3:0] funct;

    logic       a_in_ready, a_out_valid, a_illegal, a_stall;
    logic [3:0] a_op;
    logic       b_in_ready, b_out_valid, b_illegal, b_stall;
    logic [3:0] b_op;

    alu_control_mc dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .ALUOp(alu_op), .Funct(funct), .MExt(mext), .Operation(a_op),
        .out_valid(a_out_valid), .illegal(a_illegal), .stall(a_stall)
    );

    alu_control_mc #(.ENABLE_M(1'b0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .ALUOp(alu_op), .Funct(funct), .MExt(mext), .Operation(b_op),
        .out_valid(b_out_valid), .illegal(b_illegal), .stall(b_stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] op;
        bit         ill;
        int         due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    // Model state
    int         ready_at  = 0;
    logic [3:0] exp_op_a  = 4'b0010;
    bit         exp_ill_a = 1'b0;
    logic [3:0] exp_op_b  = 4'b0010;
    bit         exp_ill_b = 1'b0;

    // R-type (MExt=0) table: Funct -> op code
    logic [3:0] r_funct [10] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                                 4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011};
    logic [3:0] r_code  [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                                 4'b0111, 4'b1000, 4'b1001, 4'b0100, 4'b0101};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, got, want);
    endtask

    function automatic void ref_decode(input logic [1:0] aop, input logic [3:0] fn,
                                       input bit mx, input bit en_m,
                                       output logic [3:0] op, output bit ill, output int lat);
        op  = 4'b0010;
        ill = 1'b1;
        lat = 1;
        if (aop == 2'd0) begin
            ill = 1'b0;
            if (fn[2:0] == 3'b001) op = 4'b0111;
        end else if (aop == 2'd1) begin
            if (fn[2:0] != 3'b010 && fn[2:0] != 3'b011) begin
                ill = 1'b0;
                op  = 4'b0110;
            end
        end else if (aop == 2'd2 && mx) begin
            if (en_m) begin
                if (fn[2:0] == 3'b000)      begin op = 4'b1010; ill = 1'b0; lat = MUL_L; end
                else if (fn[2:0] == 3'b100) begin op = 4'b1011; ill = 1'b0; lat = DIV_L; end
                else if (fn[2:0] == 3'b110) begin op = 4'b1100; ill = 1'b0; lat = DIV_L; end
            end
        end else if (aop == 2'd2) begin
            for (int i = 0; i < 10; i++) begin
                if (r_funct[i] == fn) begin
                    op  = r_code[i];
                    ill = 1'b0;
                end
            end
        end
    endfunction

    // One cycle: check present outputs against the model, drive next inputs,
    // advance the model, then move to the next drive point (negedge + 1).
    task automatic step(input bit v, input logic [1:0] aop, input logic [3:0] fn,
                        input bit mx, input bit fl, input bit rs);
        bit         rdy;
        logic [3:0] op;
        bit         ill;
        int         lat;
        exp_t       e;
        rdy = (cyc >= ready_at);
        check("a_in_ready", 32'(a_in_ready), 32'(rdy));
        check("a_stall", 32'(a_stall), 32'(!rdy));
        check("a_operation_hold", 32'(a_op), 32'(exp_op_a));
        check("a_illegal_hold", 32'(a_illegal), 32'(exp_ill_a));
        check("b_in_ready", 32'(b_in_ready), 32'd1);
        check("b_stall", 32'(b_stall), 32'd0);
        check("b_operation_hold", 32'(b_op), 32'(exp_op_b));
        check("b_illegal_hold", 32'(b_illegal), 32'(exp_ill_b));

        in_valid = v; alu_op = aop; funct = fn; mext = mx; flush = fl; reset = rs;

        if (rs) begin
            qa.delete(); qb.delete();
            ready_at  = cyc + 1;
            exp_op_a  = 4'b0010; exp_ill_a = 1'b0;
            exp_op_b  = 4'b0010; exp_ill_b = 1'b0;
        end else if (fl) begin
            qa.delete(); qb.delete();
            ready_at = cyc + 1;
        end else if (v) begin
            if (rdy) begin
                ref_decode(aop, fn, mx, 1'b1, op, ill, lat);
                exp_op_a = op; exp_ill_a = ill;
                e.op = op; e.ill = ill; e.due = cyc + lat;
                qa.push_back(e);
                ready_at = cyc + lat;
            end
            ref_decode(aop, fn, mx, 1'b0, op, ill, lat);
            exp_op_b = op; exp_ill_b = ill;
            e.op = op; e.ill = ill; e.due = cyc + 1;
            qb.push_back(e);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] aop, input logic [3:0] fn, input bit mx);
        step(1'b1, aop, fn, mx, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor for dut_a
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (qa.size() > 0 && qa[0].due < cyc) begin
                    n_checks++;
                    $display("FAIL a_missing_valid: op %0h due cycle %0d, no out_valid by %0d",
                             qa[0].op, qa[0].due, cyc);
                    void'(qa.pop_front());
                end
                if (a_out_valid !== 1'b0) begin
                    if (qa.size() == 0 || qa[0].due != cyc) begin
                        n_checks++;
                        $display("FAIL a_unexpected_valid at cycle %0d: got out_valid=%b, required 0",
                                 cyc, a_out_valid);
                    end else begin
                        e = qa.pop_front();
                        check("a_out_operation", 32'(a_op), 32'(e.op));
                        check("a_out_illegal", 32'(a_illegal), 32'(e.ill));
                    end
                end
            end
        end
    end

    // Monitor for dut_b
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (qb.size() > 0 && qb[0].due < cyc) begin
                    n_checks++;
                    $display("FAIL b_missing_valid: op %0h due cycle %0d, no out_valid by %0d",
                             qb[0].op, qb[0].due, cyc);
                    void'(qb.pop_front());
                end
                if (b_out_valid !== 1'b0) begin
                    if (qb.size() == 0 || qb[0].due != cyc) begin
                        n_checks++;
                        $display("FAIL b_unexpected_valid at cycle %0d: got out_valid=%b, required 0",
                                 cyc, b_out_valid);
                    end else begin
                        e = qb.pop_front();
                        check("b_out_operation", 32'(b_op), 32'(e.op));
                        check("b_out_illegal", 32'(b_illegal), 32'(e.ill));
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] aop;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = 2'd0; funct = 4'd0; mext = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 32'(a_out_valid), 32'd0);
        check("reset_operation", 32'(a_op), 32'h2);
        check("reset_illegal", 32'(a_illegal), 32'd0);
        check("reset_stall", 32'(a_stall), 32'd0);
        ready_at = cyc;
        mon_en   = 1'b1;

        // R-type sweep, back-to-back
        for (int i = 0; i < 10; i++) issue(2'd2, r_funct[i], 1'b0);
        // Other ALUOp encodings
        issue(2'd0, 4'b1001, 1'b0);
        issue(2'd0, 4'b1010, 1'b0);
        issue(2'd1, 4'b0101, 1'b0);
        issue(2'd1, 4'b0010, 1'b0);
        issue(2'd3, 4'b0000, 1'b0);
        idle();
        // MUL with an ADD held through the stall
        issue(2'd2, 4'b0000, 1'b1);
        repeat (4) issue(2'd2, 4'b0000, 1'b0);
        idle();
        // DIV then REM back-to-back; inputs during stall are ignored
        issue(2'd2, 4'b0100, 1'b1);
        repeat (DIV_L) issue(2'd2, 4'b0110, 1'b1);
        repeat (DIV_L - 1) issue(2'd2, 4'(cyc), 1'b0);
        repeat (3) idle();
        // Flush mid-DIV
        issue(2'd2, 4'b0100, 1'b1);
        repeat (4) idle();
        step(1'b0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        repeat (20) idle();
        // Reset mid-MUL
        issue(2'd2, 4'b0000, 1'b1);
        idle();
        step(1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        repeat (6) idle();
        // Flush coincident with an accept
        step(1'b1, 2'd2, 4'b1000, 1'b0, 1'b1, 1'b0);
        repeat (2) idle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            aop = ($urandom_range(0, 9) < 6) ? 2'd2 : 2'($urandom_range(0, 3));
            step(($urandom_range(0, 9) < 7), aop, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 149) == 0));
        end

        repeat (DIV_L + 4) idle();
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
